// File: rtl/barcode_scan_sequencer.sv
// rtl/barcode_scan_sequencer.sv - bar-to-symbol packer and reader handshake sequencer
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-low reset
//   start, abort      frame control (abort wins over everything but reset)
//   bar_valid/_wide   serial bar stream in; bar_ready high only while collecting
//   I, PG             symbol and one-hot slot strobe, non-zero only in the issue cycle
//   FIM, DOIS, DEZ    reader reply flags, only looked at while waiting
//   busy, done, error frame status; err_code 01 = invalid symbol, 10 = FIM timeout
//   digit_count       valid symbols decoded in the current frame (saturating)
module barcode_scan_sequencer #(
    parameter int SYM_W      = 5,
    parameter int NUM_DIGITS = 10,
    parameter int TIMEOUT    = 255
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             bar_valid,
    input  logic             bar_wide,
    output logic             bar_ready,
    output logic [SYM_W-1:0] I,
    output logic [SYM_W-1:0] PG,
    input  logic             FIM,
    input  logic             DOIS,
    input  logic             DEZ,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [3:0]       digit_count
);

    localparam int SLOT_W = (SYM_W > 1) ? $clog2(SYM_W) : 1;
    localparam int TMR_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_ISSUE, S_WAIT, S_CHECK, S_DONE, S_ERR
    } state_t;

    state_t             state, state_nxt;
    logic [SYM_W-1:0]   sym;
    logic [SLOT_W-1:0]  bar_cnt;
    logic [SLOT_W-1:0]  slot;
    logic [TMR_W-1:0]   timer;
    logic               dois_l, dez_l;

    logic               bar_xfer;
    logic               sym_full;
    logic               wait_tmo;
    logic [3:0]         count_inc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        bar_ready = (state == S_COLLECT);
        bar_xfer  = bar_ready && bar_valid;
        sym_full  = bar_xfer && (bar_cnt == SLOT_W'(SYM_W - 1));
        // Leave WAIT on the cycle the timer would reach TIMEOUT.
        wait_tmo  = (state == S_WAIT) && !FIM && (timer == TMR_W'(TIMEOUT - 1));
        count_inc = (digit_count == 4'(NUM_DIGITS)) ? digit_count : digit_count + 4'd1;
        busy      = (state != S_IDLE) && (state != S_ERR);
        done      = (state == S_DONE);
        error     = (state == S_ERR);
        I         = (state == S_ISSUE) ? sym : '0;
        PG        = (state == S_ISSUE) ? (SYM_W'(1) << slot) : '0;

        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (start) state_nxt = S_COLLECT;
                S_COLLECT: if (sym_full) state_nxt = S_ISSUE;
                S_ISSUE:   state_nxt = S_WAIT;
                S_WAIT: begin
                    if (FIM)           state_nxt = S_CHECK;
                    else if (wait_tmo) state_nxt = S_ERR;
                end
                S_CHECK: begin
                    if (!dois_l)
                        state_nxt = S_ERR;
                    else if ((count_inc == 4'(NUM_DIGITS)) || dez_l)
                        state_nxt = S_DONE;
                    else
                        state_nxt = S_COLLECT;
                end
                S_DONE:    state_nxt = S_IDLE;
                S_ERR:     if (start) state_nxt = S_COLLECT;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sym         <= '0;
            bar_cnt     <= '0;
            slot        <= '0;
            timer       <= '0;
            dois_l      <= 1'b0;
            dez_l       <= 1'b0;
            err_code    <= 2'b00;
            digit_count <= 4'd0;
        end else if (abort) begin
            // Any partially collected symbol is dropped; the digit count survives.
            sym      <= '0;
            bar_cnt  <= '0;
            timer    <= '0;
            err_code <= 2'b00;
        end else begin
            case (state)
                S_IDLE, S_ERR: begin
                    if (start) begin
                        digit_count <= 4'd0;
                        slot        <= '0;
                        bar_cnt     <= '0;
                        err_code    <= 2'b00;
                    end
                end
                S_COLLECT: begin
                    if (bar_xfer) begin
                        sym     <= {sym[SYM_W-2:0], bar_wide};
                        bar_cnt <= sym_full ? '0 : bar_cnt + SLOT_W'(1);
                    end
                end
                S_ISSUE: timer <= '0;
                S_WAIT: begin
                    timer <= timer + TMR_W'(1);
                    if (FIM) begin
                        dois_l <= DOIS;
                        dez_l  <= DEZ;
                    end
                    if (wait_tmo) err_code <= 2'b10;
                end
                S_CHECK: begin
                    if (!dois_l) begin
                        err_code <= 2'b01;
                    end else begin
                        digit_count <= count_inc;
                        slot        <= (slot == SLOT_W'(SYM_W - 1)) ? '0 : slot + SLOT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_barcode_scan_sequencer.sv
// tb/tb_barcode_scan_sequencer.sv - directed-vector bench for barcode_scan_sequencer
module tb_barcode_scan_sequencer;

    localparam int SYM_W      = 5;
    localparam int NUM_DIGITS = 10;
    localparam int TIMEOUT    = 255;

    logic             clock = 1'b0;
    logic             reset, start, abort, bar_valid, bar_wide;
    logic             FIM, DOIS, DEZ;
    logic             bar_ready, busy, done, error;
    logic [SYM_W-1:0] I, PG;
    logic [1:0]       err_code;
    logic [3:0]       digit_count;

    int n_vec = 0;
    int n_err = 0;

    barcode_scan_sequencer #(
        .SYM_W(SYM_W), .NUM_DIGITS(NUM_DIGITS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .bar_valid(bar_valid), .bar_wide(bar_wide), .bar_ready(bar_ready),
        .I(I), .PG(PG), .FIM(FIM), .DOIS(DOIS), .DEZ(DEZ),
        .busy(busy), .done(done), .error(error),
        .err_code(err_code), .digit_count(digit_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bar(input logic w);
        int guard = 0;
        bar_valid = 1'b1;
        bar_wide  = w;
        while (!bar_ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        if (!bar_ready) check("bar_ready_wait", {31'd0, bar_ready}, 32'd1);
        @(negedge clock);
        bar_valid = 1'b0;
        bar_wide  = 1'b0;
    endtask

    task automatic send_sym(input logic [4:0] s);
        for (int i = 4; i >= 0; i--) send_bar(s[i]);
    endtask

    // Called at the negedge of the ISSUE cycle; returns one cycle after CHECK.
    task automatic reply(input logic d, input logic z);
        @(negedge clock);
        FIM = 1'b1; DOIS = d; DEZ = z;
        @(negedge clock);
        FIM = 1'b0; DOIS = 1'b0; DEZ = 1'b0;
        @(negedge clock);
    endtask

    task automatic go();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
    endtask

    logic [4:0] pats [10] = '{5'b11000, 5'b10100, 5'b10010, 5'b10001, 5'b01100,
                              5'b01010, 5'b01001, 5'b00110, 5'b00101, 5'b00011};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        bar_valid = 1'b0; bar_wide = 1'b0;
        FIM = 1'b0; DOIS = 1'b0; DEZ = 1'b0;
        #1;
        check("rst_I", I, 0);
        check("rst_PG", PG, 0);
        check("rst_flags", {bar_ready, busy, done, error}, 0);
        check("rst_err_code", err_code, 0);
        check("rst_digits", digit_count, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // 1: symbol 11000 issued on slot 0, accepted
        go();
        check("t1_collect_ready", bar_ready, 1);
        send_sym(5'b11000);
        check("t1_I", I, 5'd24);
        check("t1_PG", PG, 5'b00001);
        check("t1_ready_in_issue", bar_ready, 0);
        reply(1'b1, 1'b0);
        check("t1_digits", digit_count, 1);
        check("t1_back_collect", bar_ready, 1);

        // 2: invalid symbol 11110
        do_abort();
        check("t2_abort_keeps_digits", digit_count, 1);
        go();
        check("t2_start_clears", digit_count, 0);
        send_sym(5'b11110);
        check("t2_I", I, 5'd30);
        reply(1'b0, 1'b0);
        check("t2_error", error, 1);
        check("t2_err_code", err_code, 2'b01);
        check("t2_digits", digit_count, 0);
        check("t2_busy", busy, 0);

        // 3: FIM timeout, start from ERR
        go();
        check("t3_err_cleared", {error, err_code}, 0);
        send_sym(5'b10100);
        check("t3_I", I, 5'd20);
        for (int k = 1; k <= TIMEOUT; k++) @(negedge clock);
        check("t3_no_err_yet", error, 0);
        @(negedge clock);
        check("t3_error", error, 1);
        check("t3_err_code", err_code, 2'b10);

        // 4: full frame of ten digits, slot walks and wraps
        do_abort();
        check("t4_abort_clears_err", {error, err_code}, 0);
        go();
        for (int n = 0; n < 10; n++) begin
            send_sym(pats[n]);
            check($sformatf("t4_I_%0d", n), I, pats[n]);
            check($sformatf("t4_PG_%0d", n), PG, 32'd1 << (n % 5));
            reply(1'b1, 1'b0);
        end
        check("t4_done", done, 1);
        check("t4_digits", digit_count, 10);
        @(negedge clock);
        check("t4_done_one_cycle", {done, busy}, 0);
        check("t4_digits_hold", digit_count, 10);

        // 5: DEZ on the third symbol ends the frame
        go();
        for (int n = 0; n < 3; n++) begin
            send_sym(pats[n]);
            reply(1'b1, n == 2);
        end
        check("t5_done", done, 1);
        check("t5_digits", digit_count, 3);
        @(negedge clock);

        // 6a: async reset in the middle of COLLECT
        go();
        send_sym(5'b01100);
        reply(1'b1, 1'b0);
        send_bar(1'b1);
        send_bar(1'b1);
        #2 reset = 1'b0;
        #1;
        check("t6_rst_immediate", {bar_ready, busy, digit_count}, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // 6b: abort in WAIT, late FIM ignored
        go();
        send_sym(5'b00011);
        check("t6_fresh_symbol", I, 5'd3);
        reply(1'b1, 1'b0);
        send_sym(5'b01010);
        @(negedge clock);
        check("t6_in_wait", busy, 1);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("t6_abort_idle", {busy, done, error, bar_ready}, 0);
        FIM = 1'b1; DOIS = 1'b1;
        @(negedge clock);
        @(negedge clock);
        FIM = 1'b0; DOIS = 1'b0;
        check("t6_late_fim", {busy, done, error}, 0);
        check("t6_digits_hold", digit_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
